// File: rtl/regf_wb_queue.sv
// Write-back queue in front of the SIMD register file.
// In-order bundle FIFO with a registered regfile write port and a RAW hazard query.
package OpCodes;
  localparam int NSIG             = 15;
  localparam int ADDR_BITS_REGF   = 5;
  localparam int WRITE_PORTS_REGF = 2;
endpackage

module regf_wb_queue #(
  parameter int DEPTH            = 4,
  parameter int NSIG             = OpCodes::NSIG,
  parameter int ADDR_BITS_REGF   = OpCodes::ADDR_BITS_REGF,
  parameter int WRITE_PORTS_REGF = OpCodes::WRITE_PORTS_REGF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [WRITE_PORTS_REGF-1:0][ADDR_BITS_REGF-1:0] in_addr,
  input  logic [WRITE_PORTS_REGF-1:0][NSIG:0] in_data,
  input  logic drain_en,
  input  logic flush,
  output logic wr_en,
  output logic [WRITE_PORTS_REGF-1:0][ADDR_BITS_REGF-1:0] w_addr,
  output logic [WRITE_PORTS_REGF-1:0][NSIG:0] w_data,
  input  logic [ADDR_BITS_REGF-1:0] q_addr,
  output logic q_pending,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WRITE_PORTS_REGF-1:0][ADDR_BITS_REGF-1:0] mem_a [DEPTH];
  logic [WRITE_PORTS_REGF-1:0][NSIG:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = (count != CW'(DEPTH));
  assign push = in_valid && in_ready && !flush;
  assign pop = (count != '0) && drain_en && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_addr;
      mem_d[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_en  <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_en  <= 1'b0;
    end else begin
      wr_en <= pop;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
        w_addr <= mem_a[rd_ptr];
        w_data <= mem_d[rd_ptr];
      end
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Only the count entries from rd_ptr onward are live.
  always_comb begin
    int idx;
    idx = 0;
    q_pending = 1'b0;
    if (wr_en) begin
      for (int l = 0; l < WRITE_PORTS_REGF; l++)
        if (w_addr[l] == q_addr) q_pending = 1'b1;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = int'(rd_ptr) + k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      if (k < int'(count)) begin
        for (int l = 0; l < WRITE_PORTS_REGF; l++)
          if (mem_a[PW'(idx)][l] == q_addr) q_pending = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regf_wb_queue.sv
// Directed bench for regf_wb_queue.
// Inputs driven and outputs sampled 1ns after posedge.
module tb_regf_wb_queue;

  localparam int DEPTH = 4;
  localparam int NSIG  = 15;
  localparam int AB    = 5;
  localparam int WP    = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [WP-1:0][AB-1:0] in_addr;
  logic [WP-1:0][NSIG:0] in_data;
  logic drain_en;
  logic flush;
  logic wr_en;
  logic [WP-1:0][AB-1:0] w_addr;
  logic [WP-1:0][NSIG:0] w_data;
  logic [AB-1:0] q_addr;
  logic q_pending;
  logic [CW-1:0] count;

  int n_chk = 0;
  int n_pass = 0;

  regf_wb_queue #(
    .DEPTH(DEPTH),
    .NSIG(NSIG),
    .ADDR_BITS_REGF(AB),
    .WRITE_PORTS_REGF(WP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .in_data(in_data),
    .drain_en(drain_en),
    .flush(flush),
    .wr_en(wr_en),
    .w_addr(w_addr),
    .w_data(w_data),
    .q_addr(q_addr),
    .q_pending(q_pending),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input int a0, input int a1,
                            input int d0, input int d1);
    in_addr[0] = AB'(a0);
    in_addr[1] = AB'(a1);
    in_data[0] = 16'(d0);
    in_data[1] = 16'(d1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    drain_en = 1'b0;
    flush = 1'b0;
    q_addr = '0;
    set_bundle(0, 0, 0, 0);
    #12;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_w_addr", 32'(w_addr), 0);
    chk("rst_w_data", 32'(w_data), 0);
    rst_n = 1'b1;
    tick();

    // 1: single bundle round trip
    drain_en = 1'b1;
    in_valid = 1'b1;
    set_bundle(3, 4, 7, 8);
    tick();
    chk("t1_count_after_push", 32'(count), 1);
    chk("t1_no_same_cycle_pop", 32'(wr_en), 0);
    in_valid = 1'b0;
    tick();
    chk("t1_wr_en", 32'(wr_en), 1);
    chk("t1_w_addr0", 32'(w_addr[0]), 3);
    chk("t1_w_data0", 32'(w_data[0]), 7);
    chk("t1_w_addr1", 32'(w_addr[1]), 4);
    chk("t1_count_drained", 32'(count), 0);
    tick();
    chk("t1_wr_en_pulse", 32'(wr_en), 0);
    chk("t1_w_addr_hold", 32'(w_addr[0]), 3);

    // 2: fill to DEPTH, refuse extra, drain in order
    drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      set_bundle(10 + i, 20 + i, 100 + i, 200 + i);
      tick();
    end
    chk("t2_count_full", 32'(count), DEPTH);
    chk("t2_in_ready_full", 32'(in_ready), 0);
    set_bundle(30, 31, 999, 998);
    tick();
    chk("t2_count_refused", 32'(count), DEPTH);
    in_valid = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("t2_wr_en", 32'(wr_en), 1);
      chk("t2_w_addr0", 32'(w_addr[0]), 32'(10 + i));
      chk("t2_w_data1", 32'(w_data[1]), 32'(200 + i));
    end
    tick();
    chk("t2_wr_en_end", 32'(wr_en), 0);
    chk("t2_count_end", 32'(count), 0);

    // 3: steady push+pop across pointer wrap
    in_valid = 1'b1;
    set_bundle(0, 1, 0, 5);
    tick();
    for (int j = 1; j <= 3 * DEPTH; j++) begin
      set_bundle(j, j + 1, 3 * j, 3 * j + 5);
      tick();
      chk("t3_count", 32'(count), 1);
      chk("t3_wr_en", 32'(wr_en), 1);
      chk("t3_w_addr0", 32'(w_addr[0]), 32'(j - 1));
      chk("t3_w_data0", 32'(w_data[0]), 32'(3 * (j - 1)));
    end
    in_valid = 1'b0;
    tick();
    chk("t3_last_addr", 32'(w_addr[0]), 3 * DEPTH);
    chk("t3_last_data1", 32'(w_data[1]), 9 * DEPTH + 5);
    tick();
    chk("t3_count_end", 32'(count), 0);

    // 4: hazard query
    drain_en = 1'b0;
    in_valid = 1'b1;
    set_bundle(5, 6, 50, 60);
    tick();
    in_valid = 1'b0;
    q_addr = 5'd5;
    #1;
    chk("t4_pend_queued", 32'(q_pending), 1);
    q_addr = 5'd6;
    #1;
    chk("t4_pend_lane1", 32'(q_pending), 1);
    q_addr = 5'd9;
    #1;
    chk("t4_pend_absent", 32'(q_pending), 0);
    q_addr = 5'd5;
    drain_en = 1'b1;
    tick();
    chk("t4_wr_en", 32'(wr_en), 1);
    chk("t4_pend_outgoing", 32'(q_pending), 1);
    tick();
    chk("t4_pend_done", 32'(q_pending), 0);

    // 5: flush beats a concurrent push
    drain_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      set_bundle(i, i + 10, 10 + i, 20 + i);
      tick();
    end
    chk("t5_count3", 32'(count), 3);
    flush = 1'b1;
    set_bundle(25, 26, 999, 997);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_count_flush", 32'(count), 0);
    chk("t5_wr_en_flush", 32'(wr_en), 0);
    chk("t5_in_ready", 32'(in_ready), 1);
    q_addr = 5'd25;
    #1;
    chk("t5_pend_dropped", 32'(q_pending), 0);
    drain_en = 1'b1;
    tick();
    chk("t5_no_ghost1", 32'(wr_en), 0);
    tick();
    chk("t5_no_ghost2", 32'(wr_en), 0);

    // 6: async reset during an active write
    drain_en = 1'b0;
    in_valid = 1'b1;
    set_bundle(7, 8, 77, 88);
    tick();
    in_valid = 1'b0;
    drain_en = 1'b1;
    tick();
    chk("t6_wr_en_pre", 32'(wr_en), 1);
    chk("t6_w_data_pre", 32'(w_data[0]), 77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_wr_en_async", 32'(wr_en), 0);
    chk("t6_w_addr_async", 32'(w_addr), 0);
    chk("t6_w_data_async", 32'(w_data), 0);
    chk("t6_count_async", 32'(count), 0);
    #10;
    rst_n = 1'b1;
    tick();
    chk("t6_count_post", 32'(count), 0);
    chk("t6_wr_en_post", 32'(wr_en), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
